barcode_entry_buffer: RTL
=========================

// Module: barcode_entry_buffer
// PURPOSE
//   Parametrised digit-entry buffer for the sale terminal's barcode input path.
//   Keypad digits shift in (newest at position 0); supports backspace, clear and a
//   commit/ack handshake that freezes a complete barcode for the lookup stage.
//   Adds occupancy tracking and error flagging to plain shift-in barcode storage.
// PARAMETERS
//   DIGITS   4   number of barcode digits held (>=2)
//   DIGIT_W  4   bits per digit
//   BLANK    12  code for an empty digit position (display shows blank)
//   CNT_W    $clog2(DIGITS+1)  localparam, width of COUNT
// PORTS
//   CLOCK          in   1                 system clock, all logic on posedge
//   RESET          in   1                 synchronous, active-high reset
//   DIGIT_IN       in   DIGIT_W           digit to shift in
//   PUSH           in   1                 1-cycle strobe: shift DIGIT_IN in
//   BACKSPACE      in   1                 1-cycle strobe: remove newest digit
//   CLEAR          in   1                 1-cycle strobe: empty buffer, abort hold
//   COMMIT         in   1                 1-cycle strobe: request barcode hand-off
//   ACK            in   1                 consumer accepted BARCODE
//   DIGITS_OUT     out  DIGITS*DIGIT_W    live entry; digit k at [k*DIGIT_W +: DIGIT_W]
//   COUNT          out  CNT_W             number of valid digits, 0..DIGITS
//   EMPTY / FULL   out  1                 COUNT==0 / COUNT==DIGITS
//   BARCODE        out  DIGITS*DIGIT_W    frozen snapshot, same packing
//   BARCODE_VALID  out  1                 snapshot pending, held until ACK/CLEAR
//   ERROR          out  1                 1-cycle pulse on rejected request
// BEHAVIOUR
//   - Reset: every digit = BLANK, COUNT=0, EMPTY=1, FULL=0, BARCODE all BLANK,
//     BARCODE_VALID=0, ERROR=0, state=ENTRY. Reset beats all other inputs.
//   - States: ENTRY (editing allowed), HOLD (BARCODE_VALID=1, entry frozen).
//   - All outputs registered; effect of a strobe visible one cycle after its edge.
//   - ENTRY priority per cycle: CLEAR > COMMIT > (PUSH xor BACKSPACE).
//   - PUSH, COUNT<DIGITS: digit[k]<=digit[k-1] for k>=1, digit[0]<=DIGIT_IN, COUNT+1.
//   - PUSH, FULL: no change, ERROR pulse (no silent drop of oldest digit).
//   - BACKSPACE, COUNT>0: digit[k]<=digit[k+1], digit[DIGITS-1]<=BLANK, COUNT-1.
//   - BACKSPACE, EMPTY: no change, ERROR pulse.
//   - PUSH and BACKSPACE same cycle: no change, ERROR pulse.
//   - CLEAR: all digits BLANK, COUNT=0, no ERROR; in HOLD also drops BARCODE_VALID
//     and returns to ENTRY (BARCODE contents retained, not cleared).
//   - COMMIT, FULL: BARCODE<=DIGITS_OUT, BARCODE_VALID<=1, ->HOLD; any same-cycle
//     PUSH/BACKSPACE discarded without ERROR.
//   - COMMIT, not FULL: no transfer, ERROR pulse; same-cycle edit still applied.
//   - HOLD: PUSH/BACKSPACE/COMMIT ignored, each pulses ERROR; entry unchanged.
//   - HOLD + ACK: BARCODE_VALID<=0, entry cleared to BLANK/COUNT=0, ->ENTRY.
//     ACK with CLEAR: identical result. ACK in ENTRY: ignored, no ERROR.
//   - Digit values are not range-checked; DIGIT_IN stored verbatim (BLANK allowed).
// CONFIGURATION
//   BARCODE_ENTRY_AUTOCOMMIT_EN defined: a PUSH that makes COUNT reach DIGITS also
//     loads BARCODE with the post-shift entry and sets BARCODE_VALID on the same
//     edge (->HOLD); explicit COMMIT still accepted when FULL in ENTRY.
//   Not defined: BARCODE_VALID rises only via explicit COMMIT while FULL.
// TESTING
//   1 Reset, push 1,2,3,4 -> DIGITS_OUT digit3..0 = 1,2,3,4; COUNT=4; FULL=1; ERROR=0.
//   2 Push 7,8 then BACKSPACE -> digit0=7, digit1..3=12, COUNT=1; 2nd+3rd BACKSPACE
//     -> EMPTY=1, 3rd pulses ERROR one cycle.
//   3 Fill 5,6,7,8, 5th PUSH 9 -> unchanged, ERROR pulse; COMMIT -> BARCODE=5,6,7,8,
//     VALID=1; PUSH in HOLD -> ERROR, no change; ACK -> VALID=0, COUNT=0, digits 12.
//   4 COMMIT with COUNT=2 -> ERROR pulse, VALID stays 0; PUSH+BACKSPACE same cycle
//     -> ERROR, COUNT stays 2.
//   5 In HOLD assert CLEAR -> VALID=0, ENTRY, COUNT=0; RESET mid-entry (COUNT=3)
//     -> all outputs at reset values next cycle.
//   6 With BARCODE_ENTRY_AUTOCOMMIT_EN: push 9,0,1,2 -> VALID=1 one cycle after 4th
//     PUSH, BARCODE=9,0,1,2; without macro VALID stays 0 until COMMIT.

Source files
------------

// File: rtl/barcode_entry_buffer.sv
// Keypad digit-entry buffer with backspace/clear editing and a commit/ack hand-off of a full barcode.
// Optional feature macro: BARCODE_ENTRY_AUTOCOMMIT_EN (commit automatically when a PUSH fills the buffer).
module barcode_entry_buffer #(
    parameter  int DIGITS  = 4,
    parameter  int DIGIT_W = 4,
    parameter  int BLANK   = 12,
    localparam int CNT_W   = $clog2(DIGITS + 1)
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic [DIGIT_W-1:0]           DIGIT_IN,
    input  logic                         PUSH,
    input  logic                         BACKSPACE,
    input  logic                         CLEAR,
    input  logic                         COMMIT,
    input  logic                         ACK,
    output logic [DIGITS*DIGIT_W-1:0]    DIGITS_OUT,
    output logic [CNT_W-1:0]             COUNT,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic [DIGITS*DIGIT_W-1:0]    BARCODE,
    output logic                         BARCODE_VALID,
    output logic                         ERROR
);

    localparam int                 VEC_W    = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] BLANK_D  = DIGIT_W'(BLANK);
    localparam logic [VEC_W-1:0]   BLANK_V  = {DIGITS{BLANK_D}};
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Newest digit enters at position 0; older digits move up one position.
    function automatic logic [VEC_W-1:0] shift_in(input logic [VEC_W-1:0] v, input logic [DIGIT_W-1:0] d);
        return {v[VEC_W-DIGIT_W-1:0], d};
    endfunction

    // Drop the newest digit; the oldest position becomes blank.
    function automatic logic [VEC_W-1:0] shift_out(input logic [VEC_W-1:0] v);
        return {BLANK_D, v[VEC_W-1:DIGIT_W]};
    endfunction

    state_t             state_r, state_n;
    logic [VEC_W-1:0]   digits_r, digits_n;
    logic [VEC_W-1:0]   barcode_r, barcode_n;
    logic [CNT_W-1:0]   count_r, count_n;
    logic               error_r, error_n;
    logic               empty_r, full_r, valid_r;
    logic               is_full_s, is_empty_s;
    logic [VEC_W-1:0]   pushed_s, popped_s;

    assign is_full_s  = (count_r == CNT_FULL);
    assign is_empty_s = (count_r == CNT_ZERO);
    assign pushed_s   = shift_in(digits_r, DIGIT_IN);
    assign popped_s   = shift_out(digits_r);

    // Next-state, next-entry and error decode for both states.
    always_comb begin
        state_n   = state_r;
        digits_n  = digits_r;
        count_n   = count_r;
        barcode_n = barcode_r;
        error_n   = 1'b0;
        case (state_r)
            ST_ENTRY: begin
                if (CLEAR) begin
                    digits_n = BLANK_V;
                    count_n  = CNT_ZERO;
                end else if (COMMIT && is_full_s) begin
                    barcode_n = digits_r;
                    state_n   = ST_HOLD;
                end else begin
                    // A premature COMMIT is flagged but does not block a same-cycle edit.
                    error_n = COMMIT;
                    if (PUSH && BACKSPACE) begin
                        error_n = 1'b1;
                    end else if (PUSH) begin
                        if (is_full_s) begin
                            error_n = 1'b1;
                        end else begin
                            digits_n = pushed_s;
                            count_n  = count_r + CNT_ONE;
`ifdef BARCODE_ENTRY_AUTOCOMMIT_EN
                            if (count_r == (CNT_FULL - CNT_ONE)) begin
                                barcode_n = pushed_s;
                                state_n   = ST_HOLD;
                            end else begin
                                barcode_n = barcode_r;
                            end
`endif
                        end
                    end else if (BACKSPACE) begin
                        if (is_empty_s) begin
                            error_n = 1'b1;
                        end else begin
                            digits_n = popped_s;
                            count_n  = count_r - CNT_ONE;
                        end
                    end else begin
                        digits_n = digits_r;
                    end
                end
            end
            ST_HOLD: begin
                // BARCODE is kept after release so the consumer can still read it.
                if (CLEAR || ACK) begin
                    digits_n = BLANK_V;
                    count_n  = CNT_ZERO;
                    state_n  = ST_ENTRY;
                end else if (PUSH || BACKSPACE || COMMIT) begin
                    error_n = 1'b1;
                end else begin
                    error_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_ENTRY;
            end
        endcase
    end

    // State and registered outputs; flags are derived from the next count/state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r   <= ST_ENTRY;
            digits_r  <= BLANK_V;
            barcode_r <= BLANK_V;
            count_r   <= CNT_ZERO;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            valid_r   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            digits_r  <= digits_n;
            barcode_r <= barcode_n;
            count_r   <= count_n;
            empty_r   <= (count_n == CNT_ZERO);
            full_r    <= (count_n == CNT_FULL);
            valid_r   <= (state_n == ST_HOLD);
            error_r   <= error_n;
        end
    end

    assign DIGITS_OUT    = digits_r;
    assign COUNT         = count_r;
    assign EMPTY         = empty_r;
    assign FULL          = full_r;
    assign BARCODE       = barcode_r;
    assign BARCODE_VALID = valid_r;
    assign ERROR         = error_r;

endmodule
